fp16_normalize_round: RTL and testbench

//  Post-add normalize/round stage of the FP16 adder; sits directly downstream of the mantissa adder.

---
 rtl/fp16_pkg.sv | 26 ++
 rtl/fp16_normalize_round_lzc11.sv | 15 +
 rtl/fp16_normalize_round.sv | 135 +++++++++++++
 tb/tb_fp16_normalize_round.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 adder datapath.
package fp16_pkg;

    localparam int EXP_BIAS = 15;
    localparam int EXP_MAX  = 31;
    localparam int MANT_W   = 10;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    // Normalized beat held between the normalize and round/pack stages.
    typedef struct packed {
        logic        sign;
        logic [5:0]  exp;
        logic [10:0] mant;
        logic        g;
        logic        r;
        logic        s;
        logic        zero;
        logic        uf;
    } s1_t;

endpackage

// File: rtl/fp16_normalize_round_lzc11.sv
// Combinational 11-bit leading-zero counter; all-zero input yields 11.
module lzc11 (
    input  logic [10:0] bits,
    output logic [3:0]  count
);

    // Ascending scan so the most significant set bit is the one that sticks.
    always_comb begin
        count = 4'd11;
        for (int i = 0; i < 11; i++) begin
            if (bits[i]) count = 4'(10 - i);
        end
    end

endmodule

// File: rtl/fp16_normalize_round.sv
// FP16 post-add normalize (S1) and round-to-nearest-even/pack (S2) stage.
module fp16_normalize_round
    import fp16_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W+1:0]       in_mant,
    input  logic [2:0]              in_grs,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   out_result,
    output logic                    out_overflow,
    output logic                    out_underflow
);

    // A beat moves when its destination is empty or draining this cycle.
    logic s1_valid;
    logic s1_load;
    logic s1_advance;
    logic s2_load;
    s1_t  s1_q;
    s1_t  s1_d;

    assign s2_load    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign in_ready   = !s1_valid || s1_advance;
    assign s1_load    = in_valid && in_ready;

    logic [3:0]  lz;
    logic [12:0] sh_in;
    logic [12:0] sh1;
    logic [12:0] sh2;
    logic [12:0] sh4;
    logic [12:0] sh8;

    lzc11 u_lzc (
        .bits  (in_mant[10:0]),
        .count (lz)
    );

    // Guard and round travel with the mantissa through the left shift.
    assign sh_in = {in_mant[10:0], in_grs[2], in_grs[1]};
    assign sh1   = lz[0] ? {sh_in[11:0], 1'b0} : sh_in;
    assign sh2   = lz[1] ? {sh1[10:0], 2'b0}   : sh1;
    assign sh4   = lz[2] ? {sh2[8:0], 4'b0}    : sh2;
    assign sh8   = lz[3] ? {sh4[4:0], 8'b0}    : sh4;

    always_comb begin
        s1_d = '0;
        if (in_mant[11]) begin
            s1_d.sign = in_sign;
            s1_d.exp  = {1'b0, in_exp} + 6'd1;
            s1_d.mant = in_mant[11:1];
            s1_d.g    = in_mant[0];
            s1_d.r    = in_grs[2];
            s1_d.s    = in_grs[1] | in_grs[0];
        end else if ((in_mant == '0) || ({1'b0, in_exp} <= {2'b00, lz})) begin
            s1_d.zero = 1'b1;
            s1_d.uf   = (in_mant != '0) || (in_grs != 3'b000);
        end else begin
            s1_d.sign = in_sign;
            s1_d.exp  = {1'b0, in_exp} - {2'b00, lz};
            s1_d.mant = sh8[12:2];
            s1_d.g    = sh8[1];
            s1_d.r    = sh8[0];
            s1_d.s    = in_grs[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_d;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    logic        round_up;
    logic [11:0] sum;
    logic [5:0]  exp_r;
    logic [9:0]  frac_r;
    logic        hidden_unused;
    fp16_t       res_d;
    logic        ovf_d;
    logic        uf_d;

    assign round_up      = s1_q.g & (s1_q.r | s1_q.s | s1_q.mant[0]);
    assign sum           = {1'b0, s1_q.mant} + {11'd0, round_up};
    assign hidden_unused = sum[10];
    // A rounding carry leaves 1.000...; only the exponent changes.
    assign exp_r         = s1_q.exp + {5'd0, sum[11]};
    assign frac_r        = sum[11] ? 10'd0 : sum[9:0];

    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        uf_d  = 1'b0;
        if (s1_q.zero) begin
            uf_d = s1_q.uf;
        end else if (exp_r >= 6'(EXP_MAX)) begin
            res_d = '{sign: s1_q.sign, exp: 5'h1F, frac: 10'd0};
            ovf_d = 1'b1;
        end else begin
            res_d = '{sign: s1_q.sign, exp: exp_r[4:0], frac: frac_r};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result    <= res_d;
                out_overflow  <= ovf_d;
                out_underflow <= uf_d;
            end
        end
    end

endmodule

// File: tb/tb_fp16_normalize_round.sv
// Scoreboard bench for fp16_normalize_round driven by hand-computed directed vectors.
module tb_fp16_normalize_round;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [11:0] in_mant;
    logic [2:0]  in_grs;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_overflow;
    logic        out_underflow;

    fp16_normalize_round dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_grs        (in_grs),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        sign;
        logic [4:0]  exp;
        logic [11:0] mant;
        logic [2:0]  grs;
        logic [15:0] res;
        logic        ovf;
        logic        uf;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [0:NV-1] = '{
        '{1'b0, 5'd15, 12'h400, 3'b000, 16'h3C00, 1'b0, 1'b0},
        '{1'b0, 5'd15, 12'h800, 3'b000, 16'h4000, 1'b0, 1'b0},
        '{1'b0, 5'd15, 12'h001, 3'b000, 16'h1400, 1'b0, 1'b0},
        '{1'b0, 5'd15, 12'h7FF, 3'b100, 16'h4000, 1'b0, 1'b0},
        '{1'b0, 5'd15, 12'h400, 3'b100, 16'h3C00, 1'b0, 1'b0},
        '{1'b0, 5'd15, 12'h400, 3'b101, 16'h3C01, 1'b0, 1'b0},
        '{1'b0, 5'd30, 12'h800, 3'b000, 16'h7C00, 1'b1, 1'b0},
        '{1'b0, 5'd5,  12'h001, 3'b000, 16'h0000, 1'b0, 1'b1},
        '{1'b0, 5'd15, 12'h000, 3'b000, 16'h0000, 1'b0, 1'b0},
        '{1'b1, 5'd15, 12'h400, 3'b000, 16'hBC00, 1'b0, 1'b0},
        '{1'b1, 5'd15, 12'h000, 3'b010, 16'h0000, 1'b0, 1'b1},
        '{1'b0, 5'd15, 12'h200, 3'b110, 16'h3802, 1'b0, 1'b0},
        '{1'b0, 5'd15, 12'h803, 3'b000, 16'h4002, 1'b0, 1'b0},
        '{1'b0, 5'd30, 12'h7FF, 3'b100, 16'h7C00, 1'b1, 1'b0},
        '{1'b0, 5'd11, 12'h001, 3'b000, 16'h0400, 1'b0, 1'b0},
        '{1'b0, 5'd10, 12'h001, 3'b000, 16'h0000, 1'b0, 1'b1},
        '{1'b0, 5'd15, 12'h7FF, 3'b011, 16'h3FFF, 1'b0, 1'b0},
        '{1'b1, 5'd20, 12'h400, 3'b110, 16'hD001, 1'b0, 1'b0}
    };

    logic [17:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Present a beat at the falling edge and hold it until it is accepted.
    task automatic send(input vec_t v);
        int   waited;
        logic acc;
        logic done;
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_mant  = v.mant;
        in_grs   = v.grs;
        waited   = 0;
        done     = 1'b0;
        while (!done) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back({v.ovf, v.uf, v.res});
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", waited);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: capture mid-cycle, retire the beat on the following rising edge.
    initial begin
        logic        v;
        logic [17:0] got;
        logic [17:0] want;
        forever begin
            @(negedge clk);
            #2;
            v   = out_valid && out_ready && rst_n;
            got = {out_overflow, out_underflow, out_result};
            @(posedge clk);
            if (v) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %h expected no beat", got);
                end else begin
                    want = exp_q.pop_front();
                    check("out_beat", 32'(got), 32'(want));
                end
            end
        end
    end

    logic [15:0] hold_res;
    int          drain;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_grs    = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'h0000);
        check("rst_flags", 32'({out_overflow, out_underflow}), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-cycle latency on a lone beat.
        send(vecs[0]);
        idle();
        #1;
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        check("lat_cycle2_result", 32'(out_result), 32'h3C00);
        repeat (2) @(negedge clk);

        // Back-to-back directed vectors with the sink always ready.
        for (int i = 1; i < NV; i++) send(vecs[i]);
        idle();
        repeat (4) @(negedge clk);

        // Backpressure: the pipeline fills after two beats and holds them.
        out_ready = 1'b0;
        send(vecs[2]);
        send(vecs[5]);
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = vecs[9].sign;
        in_exp   = vecs[9].exp;
        in_mant  = vecs[9].mant;
        in_grs   = vecs[9].grs;
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        hold_res = out_result;
        check("bp_head_result", 32'(hold_res), 32'h1400);
        repeat (2) @(negedge clk);
        #1;
        check("bp_stall_in_ready", 32'(in_ready), 32'd0);
        check("bp_stall_result", 32'(out_result), 32'h1400);
        fork
            begin
                send(vecs[9]);
                send(vecs[11]);
            end
            begin
                repeat (2) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        idle();
        repeat (5) @(negedge clk);

        // Asynchronous reset with both stages occupied.
        out_ready = 1'b0;
        send(vecs[6]);
        send(vecs[0]);
        idle();
        #1;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_overflow", 32'(out_overflow), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_result", 32'(out_result), 32'h0000);
        check("async_rst_flags", 32'({out_overflow, out_underflow}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_quiet", 32'(out_valid), 32'd0);
        end
        send(vecs[17]);
        idle();

        drain = 0;
        while (exp_q.size() != 0 && drain < 200) begin
            @(negedge clk);
            drain++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
        end
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
